// File: rtl/elastic_pipe_buffer.sv
// Elastic DEPTH-stage pipeline register chain with per-stage valid bits,
// valid/ready handshake, per-stage flush and a global stall.
module elastic_pipe_buffer #(
    parameter int WIDTH         = 32,
    parameter int DEPTH         = 2,
    parameter int ZERO_ON_FLUSH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    input  logic             stall,
    input  logic [DEPTH-1:0] flush,
    output logic [DEPTH-1:0] stage_valid,
    output logic [3:0]       occupancy
);

    logic [DEPTH:0]   rdy;
    logic [DEPTH-1:0] valid_vec;
    logic [WIDTH-1:0] data_arr [DEPTH];
    logic [3:0]       occ_count;

    // Ready ripples backwards from the output; a stage can load when it is
    // empty or when the stage after it is also moving.
    always_comb begin
        rdy        = '0;
        rdy[DEPTH] = out_ready & ~stall;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            rdy[i] = ~stall & (~valid_vec[i] | rdy[i+1]);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic             valid_reg;
            logic [WIDTH-1:0] data_reg;
            logic             src_valid;
            logic [WIDTH-1:0] src_data;

            if (gi == 0) begin : g_src_in
                assign src_valid = in_valid;
                assign src_data  = in_data;
            end else begin : g_src_prev
                assign src_valid = valid_vec[gi-1];
                assign src_data  = data_arr[gi-1];
            end

            // Flush beats both stall and load; the downstream stage still
            // sees this stage's pre-flush contents in the same cycle.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    valid_reg <= 1'b0;
                    data_reg  <= '0;
                end else if (flush[gi]) begin
                    valid_reg <= 1'b0;
                    if (ZERO_ON_FLUSH != 0) begin
                        data_reg <= '0;
                    end
                end else if (rdy[gi]) begin
                    valid_reg <= src_valid;
                    data_reg  <= src_data;
                end
            end

            assign valid_vec[gi] = valid_reg;
            assign data_arr[gi]  = data_reg;
        end
    endgenerate

    always_comb begin
        occ_count = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ_count = occ_count + 4'(valid_vec[i]);
        end
    end

    assign in_ready    = rdy[0];
    assign out_valid   = valid_vec[DEPTH-1];
    assign out_data    = data_arr[DEPTH-1];
    assign stage_valid = valid_vec;
    assign occupancy   = occ_count;

endmodule

// File: tb/tb_elastic_pipe_buffer.sv
// Directed bench: instance a is DEPTH=2, instance b is DEPTH=3 (both WIDTH=8).
module tb_elastic_pipe_buffer;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_stall;
    logic [7:0] a_in_data, a_out_data;
    logic [1:0] a_flush, a_stage_valid;
    logic [3:0] a_occ;

    logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_stall;
    logic [7:0] b_in_data, b_out_data;
    logic [2:0] b_flush, b_stage_valid;
    logic [3:0] b_occ;

    int checks = 0;
    int errors = 0;

    elastic_pipe_buffer #(.WIDTH(8), .DEPTH(2), .ZERO_ON_FLUSH(1)) u_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_data(a_in_data), .in_ready(a_in_ready),
        .out_valid(a_out_valid), .out_data(a_out_data), .out_ready(a_out_ready),
        .stall(a_stall), .flush(a_flush),
        .stage_valid(a_stage_valid), .occupancy(a_occ)
    );

    elastic_pipe_buffer #(.WIDTH(8), .DEPTH(3), .ZERO_ON_FLUSH(1)) u_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
        .out_valid(b_out_valid), .out_data(b_out_data), .out_ready(b_out_ready),
        .stall(b_stall), .flush(b_flush),
        .stage_valid(b_stage_valid), .occupancy(b_occ)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Advance past the next rising edge; inputs change 2 time units later.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        a_in_valid = 0; a_in_data = 0; a_out_ready = 0; a_stall = 0; a_flush = 0;
        b_in_valid = 0; b_in_data = 0; b_out_ready = 0; b_stall = 0; b_flush = 0;
        #1;
        chk("rst_a_valid", a_out_valid, 0);
        chk("rst_a_data", a_out_data, 0);
        chk("rst_b_stage", b_stage_valid, 0);
        chk("rst_b_occ", b_occ, 0);
        tick(); tick();
        rst = 1;
        #1;
        chk("rst_a_stage", a_stage_valid, 0);
        chk("rst_a_occ", a_occ, 0);
        chk("empty_a_rdy", a_in_ready, 1);

        // Stream through DEPTH=2.
        a_out_ready = 1; a_in_valid = 1; a_in_data = 8'h11;
        #1 chk("str_rdy0", a_in_ready, 1);
        tick();
        chk("str_ov_e1", a_out_valid, 0);
        chk("str_rdy1", a_in_ready, 1);
        a_in_data = 8'h22;
        tick();
        chk("str_ov_e2", a_out_valid, 1);
        chk("str_d_e2", a_out_data, 8'h11);
        a_in_data = 8'h33;
        tick();
        chk("str_d_e3", a_out_data, 8'h22);
        chk("str_rdy3", a_in_ready, 1);
        a_in_valid = 0;
        tick();
        chk("str_d_e4", a_out_data, 8'h33);
        chk("str_occ_e4", a_occ, 1);
        tick();
        chk("str_ov_e5", a_out_valid, 0);

        // Backpressure fill on DEPTH=3.
        b_in_valid = 1; b_in_data = 8'h0A;
        #1 chk("bp_rdy_a", b_in_ready, 1);
        tick(); b_in_data = 8'h0B;
        #1 chk("bp_rdy_b", b_in_ready, 1);
        tick(); b_in_data = 8'h0C;
        #1 chk("bp_rdy_c", b_in_ready, 1);
        tick(); b_in_data = 8'h0D;
        #1;
        chk("bp_full_rdy", b_in_ready, 0);
        chk("bp_full_occ", b_occ, 3);
        chk("bp_full_d", b_out_data, 8'h0A);
        tick();
        chk("bp_hold_sv", b_stage_valid, 3'b111);
        chk("bp_hold_d", b_out_data, 8'h0A);
        b_out_ready = 1;
        #1 chk("bp_rdy_open", b_in_ready, 1);
        tick(); b_in_valid = 0;
        chk("bp_out_b", b_out_data, 8'h0B);
        chk("bp_occ_swap", b_occ, 3);
        tick();
        chk("bp_out_c", b_out_data, 8'h0C);
        tick();
        chk("bp_out_d", b_out_data, 8'h0D);
        chk("bp_out_dv", b_out_valid, 1);
        tick();
        chk("bp_drained", b_occ, 0);

        // Bubble collapse on DEPTH=3.
        b_out_ready = 0; b_in_valid = 1; b_in_data = 8'h05;
        tick(); b_in_valid = 0;
        chk("bub_sv1", b_stage_valid, 3'b001);
        tick();
        chk("bub_sv2", b_stage_valid, 3'b010);
        tick();
        chk("bub_sv3", b_stage_valid, 3'b100);
        b_in_valid = 1; b_in_data = 8'h06;
        tick(); b_in_valid = 0;
        chk("bub_sv4", b_stage_valid, 3'b101);
        tick();
        chk("bub_sv5", b_stage_valid, 3'b110);
        chk("bub_occ", b_occ, 2);
        chk("bub_d", b_out_data, 8'h05);

        // Selective flush on DEPTH=2: stage1=0x2, stage0=0x1.
        a_out_ready = 0; a_in_valid = 1; a_in_data = 8'h02;
        tick(); a_in_data = 8'h01;
        tick(); a_in_valid = 0;
        chk("fl_pre_sv", a_stage_valid, 2'b11);
        a_flush = 2'b10;
        tick(); a_flush = 2'b00;
        chk("fl_sv", a_stage_valid, 2'b01);
        chk("fl_zero", a_out_data, 0);
        chk("fl_ov", a_out_valid, 0);
        a_out_ready = 1;
        tick();
        chk("fl_next_ov", a_out_valid, 1);
        chk("fl_next_d", a_out_data, 8'h01);
        tick();

        // Stall priority: full chain 0x44/0x55, stall with flush of stage 0.
        a_out_ready = 0; a_in_valid = 1; a_in_data = 8'h44;
        tick(); a_in_data = 8'h55;
        tick(); a_in_data = 8'h66;
        a_stall = 1; a_out_ready = 1; a_flush = 2'b01;
        #1 chk("st_rdy", a_in_ready, 0);
        tick();
        a_stall = 0; a_flush = 2'b00; a_out_ready = 0; a_in_data = 8'h77;
        chk("st_sv", a_stage_valid, 2'b10);
        chk("st_d", a_out_data, 8'h44);

        // A flushed source stage still hands its old word downstream.
        tick(); a_in_valid = 0;
        chk("fs_full", a_stage_valid, 2'b11);
        a_out_ready = 1; a_flush = 2'b01;
        tick(); a_flush = 2'b00; a_out_ready = 0;
        chk("fs_d", a_out_data, 8'h77);
        chk("fs_sv", a_stage_valid, 2'b10);

        // Asynchronous reset between edges with two words in flight.
        a_in_valid = 1; a_in_data = 8'h88;
        tick(); a_in_valid = 0;
        chk("ar_pre_occ", a_occ, 2);
        #2 rst = 0;
        #1;
        chk("ar_ov", a_out_valid, 0);
        chk("ar_sv", a_stage_valid, 0);
        chk("ar_occ", a_occ, 0);
        chk("ar_d", a_out_data, 0);
        tick();
        rst = 1;
        a_out_ready = 1; a_in_valid = 1; a_in_data = 8'h99;
        tick(); a_in_valid = 0;
        chk("ar_lat1", a_out_valid, 0);
        tick();
        chk("ar_lat2_v", a_out_valid, 1);
        chk("ar_lat2_d", a_out_data, 8'h99);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/elastic_pipe_buffer.md
Name: elastic_pipe_buffer

Overview:
- Parametrised successor to the fixed two-stage ID/EX pipeline registers.
- Provides a DEPTH-deep chain of WIDTH-bit payload registers, each with its own valid bit.
- Uses an elastic valid/ready handshake: stages advance independently, so bubbles collapse.
- Supports per-stage selective flush and a global stall. Used between decode and the split execute stages, and anywhere a multi-cycle, flushable pipeline segment is needed.

Parameters:
- WIDTH, 32, payload bits per stage (the bundled control+data word).
- DEPTH, 2, number of register stages; legal range 1..8.
- ZERO_ON_FLUSH, 1, 1 = flushed or reset stages also clear payload to 0; 0 = payload keeps its old value and only valid clears.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream has a word on in_data.
- in_data  in  WIDTH  upstream payload.
- in_ready  out  1  stage 0 accepts this cycle.
- out_valid  out  1  valid bit of stage DEPTH-1.
- out_data  out  WIDTH  payload of stage DEPTH-1.
- out_ready  in  1  downstream consumes this cycle.
- stall  in  1  global hold; no stage loads or drains.
- flush  in  DEPTH  bit i invalidates stage i at the next edge.
- stage_valid  out  DEPTH  valid bits of all stages, bit i = stage i.
- occupancy  out  4  count of valid stages, range 0..DEPTH.

Behaviour:
- Reset (rst=0, asynchronous): every valid bit = 0 and every payload = 0, regardless of ZERO_ON_FLUSH. Resulting outputs: out_valid=0, out_data=0, stage_valid=0, occupancy=0. If reset is asserted mid-transfer, in-flight words are lost; there is no replay.
- Ready chain (combinational):
  - rdy[DEPTH] = out_ready & ~stall.
  - rdy[i] = ~stall & (~valid[i] | rdy[i+1]).
  - in_ready = rdy[0].
  - The path from out_ready to in_ready is purely combinational by design; no skid register.
- Stage update at each rising edge, in priority order:
  1. flush[i]=1 -> valid[i] <= 0; payload[i] <= 0 if ZERO_ON_FLUSH. Flush wins over stall and over any load into stage i.
  2. Else if rdy[i]=1 -> valid[i] <= source valid; payload[i] <= source payload. The source is in_valid/in_data for i=0, and stage i-1 otherwise.
  3. Else -> hold.
- Payload on bubble load: when rdy[i]=1 and the source is invalid, valid[i] <= 0 and payload[i] <= source payload. Payload under valid=0 is don't-care for consumers; the bench must not check it.
- Flushed source stage: if flush[i-1]=1 and rdy[i]=1 in the same cycle, stage i still receives the pre-flush contents of stage i-1. Flush acts only on the stage it names.
- Transfer definitions:
  - Input transfer: in_valid & in_ready.
  - Output transfer: out_valid & out_ready & ~stall.
  - in_data is never sampled when in_ready=0. Upstream holds in_data stable while in_valid=1 and in_ready=0.
- Latency and throughput: with no stall, no flush and out_ready=1, a word accepted at edge n appears on out_data after edge n+DEPTH-1, i.e. DEPTH cycles of register delay. Sustained throughput is 1 word per cycle.
- Full: all valid bits = 1 and out_ready=0 -> in_ready=0 and every stage holds.
- Empty: all valid bits = 0 -> in_ready = ~stall; out_valid=0.
- Simultaneous consume and accept when full and out_ready=1: the whole chain shifts and occupancy is unchanged.
- Stall: freezes all valid bits and payloads except flushed stages. Neither output nor input transfers occur.
- occupancy is the combinational popcount of the registered valid bits, zero-extended to 4 bits.
- DEPTH=1 degenerates to a single register with the same rules.

Test Plan:
- Stream: DEPTH=2, out_ready=1, in_data=0x11,0x22,0x33 on consecutive cycles -> out_data 0x11,0x22,0x33 with out_valid first high 2 cycles after the first accept; in_ready stays 1.
- Backpressure fill: DEPTH=3, out_ready=0, push 0xA,0xB,0xC,0xD -> 0xA..0xC accepted, in_ready=0 while 0xD is held, occupancy=3. Then out_ready=1 -> outputs 0xA,0xB,0xC,0xD in order, no loss, no duplication.
- Bubble collapse: DEPTH=3, push 0x5, idle 1 cycle, then out_ready=0 and push 0x6 -> stage_valid goes 3'b100 then 3'b110; occupancy=2.
- Selective flush: DEPTH=2 holding 0x1 (stage 0) and 0x2 (stage 1), out_ready=0, flush=2'b10 -> stage_valid=2'b01, out_data=0 (ZERO_ON_FLUSH=1); the next edge with out_ready=1 outputs 0x1.
- Stall priority: full chain, stall=1, out_ready=1, flush=2'b01 -> in_ready=0, no output transfer, stage 1 unchanged, stage 0 cleared.
- Async reset mid-stream: drive rst=0 between edges with occupancy=2 -> out_valid, stage_valid and occupancy drop to 0 immediately without a clock edge; after release the first push reappears after DEPTH cycles.
